// File: rtl/pipelined_prefix_adder_pkg.sv
// prefix_adder_pkg: shared types and elaboration-time helpers for the
// pipelined Brent-Kung adder.
//   gp_t           generate/propagate pair carried through the prefix tree
//   gp_combine     prefix operator: (g,p)hi o (g,p)lo
//   up_levels      number of up-sweep levels for a given width
//   prefix_levels  total prefix levels (up-sweep + down-sweep)
//   level_lo       first prefix level owned by a pipeline stage
//   level_stage    pipeline stage that owns a given prefix level
package prefix_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic int up_levels(input int width);
        return $clog2(width);
    endfunction

    // Brent-Kung: log2 levels up, one fewer down.
    function automatic int prefix_levels(input int width);
        return 2 * $clog2(width) - 1;
    endfunction

    function automatic int level_lo(input int stage, input int stages, input int nl);
        return (stage * nl) / stages;
    endfunction

    function automatic int level_stage(input int level, input int stages, input int nl);
        int r;
        r = 0;
        for (int k = 0; k < stages; k++) begin
            if (level >= level_lo(k, stages, nl) && level < level_lo(k + 1, stages, nl))
                r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// pipelined_prefix_adder_if: valid/ready operand and result streams of the
// pipelined prefix adder.
//   in_valid/in_ready          operand beat handshake
//   in_a, in_b, in_cin, in_sub operands, carry-in, 0=add 1=subtract
//   out_valid/out_ready        result beat handshake
//   out_sum, out_cout          result and carry-out (1 = no borrow in subtract)
//   out_ovf                    signed overflow, only when PREFIX_ADDER_OVF_EN is defined
// Modports: master drives operands and out_ready, slave is the adder.
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef PREFIX_ADDER_OVF_EN
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
`ifdef PREFIX_ADDER_OVF_EN
        , input out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout
`ifdef PREFIX_ADDER_OVF_EN
        , output out_ovf
`endif
    );

endinterface

// File: rtl/pipelined_prefix_adder_level.sv
// prefix_level: one level of a Brent-Kung prefix tree (purely combinational).
//   WIDTH   number of bit positions
//   LEVEL   level index k within its sweep; nodes combine with position i-2^k
//   UP      1 = up-sweep level, 0 = down-sweep level
//   gp_in   generate/propagate pairs entering the level
//   gp_out  generate/propagate pairs leaving the level
module prefix_level
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 0,
    parameter bit UP    = 1'b1
) (
    input  gp_t [WIDTH-1:0] gp_in,
    output gp_t [WIDTH-1:0] gp_out
);
    localparam int SPAN = 1 << LEVEL;

    for (genvar i = 0; i < WIDTH; i++) begin : g_node
        // Up-sweep closes blocks ending on a 2^(k+1) boundary; down-sweep
        // fills in the mid-block positions from the block prefix below them.
        // Positions past WIDTH never act as sources, so non power-of-two
        // widths behave like a truncated power-of-two tree.
        localparam bit ACTIVE = UP ? (((i + 1) % (2 * SPAN)) == 0)
                                   : ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 3 * SPAN - 1));
        if (ACTIVE) begin : g_comb
            assign gp_out[i] = gp_combine(gp_in[i], gp_in[i - SPAN]);
        end else begin : g_pass
            assign gp_out[i] = gp_in[i];
        end
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: WIDTH-bit add/subtract built on a Brent-Kung
// prefix carry network, split evenly across STAGES register boundaries with
// a global valid/ready stall.
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset (clears valids and output registers)
//   bus  pipelined_prefix_adder_if.slave operand/result streams
// Optional feature: define PREFIX_ADDER_OVF_EN to add the out_ovf result.
module pipelined_prefix_adder
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    pipelined_prefix_adder_if.slave bus
);
    localparam int NL   = prefix_levels(WIDTH);
    localparam int NUP  = up_levels(WIDTH);
    localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LAST = STAGES - 1;

    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [WIDTH-1:0]  prop_gen;
    gp_t  [WIDTH-1:0]  gp_gen;

    gp_t  [WIDTH-1:0]  node_in   [NL];
    gp_t  [WIDTH-1:0]  node_out  [NL];
    gp_t  [WIDTH-1:0]  gp_in_s   [STAGES];
    gp_t  [WIDTH-1:0]  gp_out_s  [STAGES];
    logic [WIDTH-1:0]  prop_in_s [STAGES];
    logic              cin_in_s  [STAGES];

    gp_t  [WIDTH-1:0]  gp_p   [NREG];
    logic [WIDTH-1:0]  prop_p [NREG];
    logic              cin_p  [NREG];
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] vld_next;

    logic [WIDTH-1:0]  carry;
    logic [WIDTH-1:0]  sum_c;
    logic              cout_c;
    logic [WIDTH-1:0]  sum_p;
    logic              cout_p;

    // Whole pipeline moves together; reset forces readiness.
    assign adv          = rst || !vld_p[LAST] || bus.out_ready;
    assign bus.in_ready = adv;

    // ---- operand conditioning: subtract is a + ~b + 1 ----
    assign b_eff    = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign cin_eff  = bus.in_sub || bus.in_cin;
    assign prop_gen = bus.in_a ^ b_eff;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            gp_gen[i].g = bus.in_a[i] & b_eff[i];
            gp_gen[i].p = prop_gen[i];
        end
        // Carry-in folded into bit 0, so each prefix g is the carry out of that bit.
        gp_gen[0].g = (bus.in_a[0] & b_eff[0]) | (prop_gen[0] & cin_eff);
    end

    // ---- prefix levels, each owned by one pipeline stage ----
    for (genvar l = 0; l < NL; l++) begin : g_level
        localparam bit IS_UP = (l < NUP);
        localparam int K     = IS_UP ? l : (2 * NUP - 2 - l);
        localparam int ST    = level_stage(l, STAGES, NL);
        localparam int LO    = level_lo(ST, STAGES, NL);
        if (l == LO) begin : g_first
            assign node_in[l] = gp_in_s[ST];
        end else begin : g_chain
            assign node_in[l] = node_out[l - 1];
        end
        prefix_level #(
            .WIDTH (WIDTH),
            .LEVEL (K),
            .UP    (IS_UP)
        ) u_level (
            .gp_in  (node_in[l]),
            .gp_out (node_out[l])
        );
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = level_lo(s, STAGES, NL);
        localparam int HI = level_lo(s + 1, STAGES, NL);
        if (s == 0) begin : g_src
            assign gp_in_s[s]   = gp_gen;
            assign prop_in_s[s] = prop_gen;
            assign cin_in_s[s]  = cin_eff;
        end else begin : g_reg
            assign gp_in_s[s]   = gp_p[s - 1];
            assign prop_in_s[s] = prop_p[s - 1];
            assign cin_in_s[s]  = cin_p[s - 1];
        end
        if (HI > LO) begin : g_work
            assign gp_out_s[s] = node_out[HI - 1];
        end else begin : g_thru
            assign gp_out_s[s] = gp_in_s[s];
        end
    end

    // ---- stage boundaries _p0.._p(STAGES-2): intermediate prefix state ----
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int s = 0; s < STAGES - 1; s++) begin
                gp_p[s]   <= gp_out_s[s];
                prop_p[s] <= prop_in_s[s];
                cin_p[s]  <= cin_in_s[s];
            end
        end
    end

    always_comb begin
        vld_next    = vld_p << 1;
        vld_next[0] = bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst)
            vld_p <= '0;
        else if (adv)
            vld_p <= vld_next;
    end

    // ---- final stage: sum = p ^ carry-in of each bit ----
    always_comb begin
        carry[0] = cin_in_s[LAST];
        for (int i = 1; i < WIDTH; i++)
            carry[i] = gp_out_s[LAST][i - 1].g;
        sum_c  = prop_in_s[LAST] ^ carry;
        cout_c = gp_out_s[LAST][WIDTH - 1].g;
    end

    // ---- output boundary: drives the result port directly ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p  <= '0;
            cout_p <= 1'b0;
        end else if (adv) begin
            sum_p  <= sum_c;
            cout_p <= cout_c;
        end
    end

    assign bus.out_valid = vld_p[LAST];
    assign bus.out_sum   = sum_p;
    assign bus.out_cout  = cout_p;

`ifdef PREFIX_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    logic ovf_c;
    logic ovf_p;
    assign ovf_c = carry[WIDTH - 1] ^ cout_c;

    always_ff @(posedge clk) begin
        if (rst)
            ovf_p <= 1'b0;
        else if (adv)
            ovf_p <= ovf_c;
    end

    assign bus.out_ovf = ovf_p;
`endif

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder: directed and randomized check of the pipelined
// prefix adder (WIDTH=12, STAGES=2) against an arithmetic reference model.
// Define PREFIX_ADDER_OVF_EN to also check out_ovf.
module tb_pipelined_prefix_adder;
    localparam int W = 12;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_prefix_adder_if #(.WIDTH(W)) ifc ();

    pipelined_prefix_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct packed {
        logic         ovf;
        logic         cout;
        logic [W-1:0] sum;
    } res_t;

    res_t         exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc = 0;
    int           push_cyc = 0;
    int           pop_cyc = 0;
    int           n_pop = 0;
    int           n_push = 0;
    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_ovf;
    logic         last_in_ready;
    logic         hold_prev = 1'b0;

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t   r;
        longint ua, ub, sa, sb, ss, total, lim;
        ua  = longint'(a);
        ub  = longint'(b);
        lim = longint'(1) << (W - 1);
        sa  = a[W-1] ? ua - (longint'(1) << W) : ua;
        sb  = b[W-1] ? ub - (longint'(1) << W) : ub;
        if (sub) begin
            total  = ua - ub;
            r.cout = (ua >= ub);
            ss     = sa - sb;
        end else begin
            total  = ua + ub + longint'(cin);
            r.cout = total[W];
            ss     = sa + sb + longint'(cin);
        end
        r.sum = total[W-1:0];
        r.ovf = (ss > lim - 1) || (ss < -lim);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        ifc.in_valid = v;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_cin   = cin;
        ifc.in_sub   = sub;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic tick();
        res_t e;
        @(negedge clk);
        cyc++;
        last_in_ready = ifc.in_ready;
        if (rst) begin
            check("rst_in_ready", ifc.in_ready, 1);
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                check("hold_valid", ifc.out_valid, 1);
            check("in_ready_rule", ifc.in_ready, !ifc.out_valid || ifc.out_ready);
            if (ifc.out_valid && !ifc.out_ready && exp_q.size() > 0)
                check("stall_data", {ifc.out_cout, ifc.out_sum}, {exp_q[0].cout, exp_q[0].sum});
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", ifc.out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", ifc.out_sum, e.sum);
                    check("cout", ifc.out_cout, e.cout);
`ifdef PREFIX_ADDER_OVF_EN
                    check("ovf", ifc.out_ovf, e.ovf);
                    last_ovf = ifc.out_ovf;
`endif
                    last_sum  = ifc.out_sum;
                    last_cout = ifc.out_cout;
                    pop_cyc   = cyc;
                    n_pop++;
                end
            end
            if (ifc.in_valid && ifc.in_ready) begin
                exp_q.push_back(model(ifc.in_a, ifc.in_b, ifc.in_cin, ifc.in_sub));
                push_cyc = cyc;
                n_push++;
            end
            hold_prev = ifc.out_valid && !ifc.out_ready;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int push_base;

        // Reset state
        rst           = 1'b1;
        ifc.out_ready = 1'b0;
        drive_rand(1'b0);
        tick();
        tick();
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_out_sum", ifc.out_sum, 0);
        check("rst_out_cout", ifc.out_cout, 0);
`ifdef PREFIX_ADDER_OVF_EN
        check("rst_out_ovf", ifc.out_ovf, 0);
`endif
        rst = 1'b0;
        exp_q.delete();
        ifc.out_ready = 1'b1;

        // 0xFFF + 0x001: wraps to 0 with carry, latency STAGES
        drive(1'b1, 12'hFFF, 12'h001, 1'b0, 1'b0);
        tick();
        drive_rand(1'b0);
        repeat (4) tick();
        check("latency", pop_cyc - push_cyc, S);
        check("wrap_sum", last_sum, 12'h000);
        check("wrap_cout", last_cout, 1);

        // Subtract with borrow (cin must be ignored), then without
        drive(1'b1, 12'h005, 12'h007, 1'b1, 1'b1);
        tick();
        drive_rand(1'b0);
        repeat (4) tick();
        check("sub_borrow_sum", last_sum, 12'hFFE);
        check("sub_borrow_cout", last_cout, 0);
        drive(1'b1, 12'h007, 12'h005, 1'b0, 1'b1);
        tick();
        drive_rand(1'b0);
        repeat (4) tick();
        check("sub_sum", last_sum, 12'h002);
        check("sub_cout", last_cout, 1);

`ifdef PREFIX_ADDER_OVF_EN
        drive(1'b1, 12'h7FF, 12'h001, 1'b0, 1'b0);
        tick();
        drive_rand(1'b0);
        repeat (4) tick();
        check("ovf_add_pos", last_ovf, 1);
        drive(1'b1, 12'h800, 12'h001, 1'b0, 1'b1);
        tick();
        drive_rand(1'b0);
        repeat (4) tick();
        check("ovf_sub_neg", last_ovf, 1);
        drive(1'b1, 12'h001, 12'h001, 1'b0, 1'b0);
        tick();
        drive_rand(1'b0);
        repeat (4) tick();
        check("ovf_none", last_ovf, 0);
`endif

        // 8 back-to-back beats with a downstream stall in cycles 3..6
        base      = n_pop;
        push_base = n_push;
        for (int c = 0; c < 40 && (n_pop - base < 8 || n_push - push_base < 8); c++) begin
            drive_rand(n_push - push_base < 8);
            ifc.out_ready = !(c >= 3 && c <= 6);
            tick();
            if (c == 4)
                check("stall_in_ready", last_in_ready, 0);
        end
        drive_rand(1'b0);
        ifc.out_ready = 1'b1;
        check("stall_beats_in", n_push - push_base, 8);
        check("stall_beats_out", n_pop - base, 8);

        // Reset with two beats in flight
        drive_rand(1'b1);
        tick();
        drive_rand(1'b1);
        tick();
        drive_rand(1'b0);
        rst           = 1'b1;
        ifc.out_ready = 1'b0;
        tick();
        check("midrst_out_valid", ifc.out_valid, 0);
        check("midrst_out_sum", ifc.out_sum, 0);
        check("midrst_in_ready", ifc.in_ready, 1);
        exp_q.delete();
        rst           = 1'b0;
        ifc.out_ready = 1'b1;
        base          = n_pop;
        repeat (6) tick();
        check("no_stale", n_pop - base, 0);

        // Random valid/ready traffic
        base      = n_pop;
        push_base = n_push;
        for (int c = 0; c < 4000; c++) begin
            drive_rand($urandom_range(0, 9) < 7);
            ifc.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drive_rand(1'b0);
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++)
            tick();
        check("drain_empty", exp_q.size(), 0);
        check("random_count", n_pop - base, n_push - push_base);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
